uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer sitting directly downstream of the UART receiver and upstream of the AXI-Lite read mux for register 0x0C (UART RX data).
- Absorbs bytes arriving at line rate so software can read bursts without loss.
- Reports fill level, overrun and a threshold interrupt to the status register at 0x04.
- First-word-fall-through (FWFT): the head byte is always presented on rd_data.

Parameters:
DEPTH, 16, number of 8-bit entries; power of 2, minimum 2.
LEVEL_W, $clog2(DEPTH)+1, width of level/threshold fields; derived, not overridden.
TIMEOUT_CYCLES, 20832, idle ACLK cycles before the timeout flag (4 bit-times at 9600 baud, 50 MHz).

Ports:
ACLK  in  1  system clock; all logic is on the rising edge.
ARESET  in  1  asynchronous, active-high reset.
rx_byte_valid  in  1  single-cycle strobe from the UART receiver: a byte is complete.
rx_byte  in  8  received byte; qualified by rx_byte_valid.
rd_pop  in  1  single-cycle strobe from the AXI slave on an accepted read of 0x0C.
flush  in  1  synchronous clear of the FIFO contents.
thresh  in  LEVEL_W  interrupt threshold from the control register; 0 disables it.
overrun_clr  in  1  single-cycle clear of the sticky overrun flag (write-1-to-clear path).
rd_data  out  8  head byte; 0x00 when empty.
empty  out  1  level == 0.
full  out  1  level == DEPTH.
level  out  LEVEL_W  number of stored bytes.
overrun  out  1  sticky: a byte was dropped because the FIFO was full.
thresh_irq  out  1  registered: level >= thresh and thresh != 0.
timeout_irq  out  1  idle-timeout flag; constant 0 unless the feature is compiled in.

Behaviour:
- Reset (async assert, sync release): wr_ptr = rd_ptr = 0, level = 0, overrun = 0, thresh_irq = 0, timeout_irq = 0, timeout counter = 0. Outputs after reset: empty = 1, full = 0, rd_data = 0x00. Memory contents are not reset.
- Storage: circular buffer with LEVEL_W-bit pointers. The MSB is the wrap bit; the index is the low $clog2(DEPTH) bits. Wrap from DEPTH-1 to 0 is natural overflow.
- Push: rx_byte_valid and not full. Write mem[wr_ptr], then wr_ptr+1, level+1.
- Pop: rd_pop and not empty. rd_ptr+1, level-1. A pop while empty is ignored, with no underflow and no error.
- rd_data: combinational mem[rd_ptr[idx]] gated to 0x00 when empty. A byte is visible on rd_data the cycle after its push.
- Simultaneous push and pop:
  - Not empty: both happen, level unchanged. This includes the full case, because the slot is freed the same cycle.
  - Empty: push only; the pop is ignored.
- Full, no pop, rx_byte_valid = 1: the byte is dropped, contents are unchanged, and overrun is set next cycle.
- overrun: set has priority over overrun_clr in the same cycle. flush does not clear it.
- flush: next cycle wr_ptr = rd_ptr = 0, level = 0, timeout_irq = 0. flush overrides a push or pop in the same cycle, and that byte is discarded.
- thresh_irq: registered compare of the next-state level against thresh, so it asserts 1 cycle after the push that reaches the threshold. It deasserts once level drops below thresh or thresh = 0.
- full and empty are derived from level; level is a registered counter.

Optional Feature:
UART_RX_FIFO_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) resets to 0 on any push, pop or flush.
  - It increments while level != 0 and saturates at TIMEOUT_CYCLES.
  - timeout_irq is set when the count reaches TIMEOUT_CYCLES. It is sticky until the next pop, push or flush.
  - It never asserts while empty.
- Undefined: no counter logic; timeout_irq is tied to 0 and the port remains present.

Decomposition:
- Package axi_multi_pkg holds:
  - UART_DATA_W = 8
  - register offsets: REG_CTRL 0x00, REG_STATUS 0x04, REG_UART_RX 0x0C
  - status bit positions for empty, full, overrun, thresh_irq, timeout_irq
- Sub-module uart_fifo_ram: DEPTH x 8 register array with one synchronous write port and one asynchronous read port, with no reset. The control and pointer logic stays in uart_rx_fifo.

Test Plan:
- Reset, then push 0x83 → next cycle rd_data = 0x83, level = 1, empty = 0. Pulse rd_pop → empty = 1, rd_data = 0x00.
- Push 0x00..0x0F (DEPTH = 16) → full = 1, level = 16. Push 0xAA → overrun = 1, and 16 pops return 0x00..0x0F in order with 0xAA absent. overrun_clr → overrun = 0.
- Full FIFO, same-cycle push 0x55 + pop → level stays 16, overrun stays 0, and the last byte popped is 0x55. Same cycle on an empty FIFO: level = 1, rd_data = 0x55.
- thresh = 4: on push 1→3, thresh_irq = 0. It is 1 one cycle after the 4th push, and 0 after one pop (level 3). With thresh = 0 at level 16, thresh_irq = 0.
- flush with level = 7 and a simultaneous push → level = 0, empty = 1. Then push 0x41 → rd_data = 0x41. overrun keeps its prior value.
- With UART_RX_FIFO_TIMEOUT_EN, push 1 byte and wait 20832 cycles → timeout_irq = 1, and a pop clears it. The same idle wait with the FIFO empty → timeout_irq stays 0. Without the macro, timeout_irq = 0 throughout.

Source files
------------

// File: rtl/axi_multi_pkg.sv
// Shared definitions for the AXI-Lite multi-peripheral slice: UART data
// width, register map offsets and status register bit positions.
package axi_multi_pkg;

   localparam int UART_DATA_W = 8;

   // Register map offsets
   localparam logic [7:0] REG_CTRL    = 8'h00;
   localparam logic [7:0] REG_STATUS  = 8'h04;
   localparam logic [7:0] REG_UART_RX = 8'h0C;

   // Bit positions inside REG_STATUS
   localparam int STAT_EMPTY_BIT       = 0;
   localparam int STAT_FULL_BIT        = 1;
   localparam int STAT_OVERRUN_BIT     = 2;
   localparam int STAT_THRESH_IRQ_BIT  = 3;
   localparam int STAT_TIMEOUT_IRQ_BIT = 4;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x UART_DATA_W register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module uart_fifo_ram
   import axi_multi_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic                   ACLK,
   input  logic                   we,
   input  logic [IDX_W-1:0]       waddr,
   input  logic [UART_DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]       raddr,
   output logic [UART_DATA_W-1:0] rdata
);

   logic [UART_DATA_W-1:0] mem [DEPTH];

   // Write port: store the byte on the rising edge when enabled
   always_ff @(posedge ACLK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO (first-word-fall-through) feeding the RX data register.
// Tracks fill level, a sticky overrun flag and a registered threshold
// interrupt. Define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout flag;
// otherwise timeout_irq is tied low.
module uart_rx_fifo
   import axi_multi_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 20832,
   localparam int LEVEL_W       = $clog2(DEPTH) + 1
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic                   rx_byte_valid,
   input  logic [UART_DATA_W-1:0] rx_byte,
   input  logic                   rd_pop,
   input  logic                   flush,
   input  logic [LEVEL_W-1:0]     thresh,
   input  logic                   overrun_clr,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [LEVEL_W-1:0]     level,
   output logic                   overrun,
   output logic                   thresh_irq,
   output logic                   timeout_irq
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [LEVEL_W-1:0]     wr_ptr;
   logic [LEVEL_W-1:0]     rd_ptr;
   logic [LEVEL_W-1:0]     level_nxt;
   logic [UART_DATA_W-1:0] ram_rdata;
   logic                   pop_ok;
   logic                   push_ok;
   logic                   drop;

   assign empty = (level == '0);
   assign full  = (level == LEVEL_W'(DEPTH));

   // A pop frees the head slot in the same cycle, so a full FIFO still
   // accepts a byte when it is popped at the same time.
   assign pop_ok  = rd_pop & ~empty;
   assign push_ok = rx_byte_valid & (~full | pop_ok);
   assign drop    = rx_byte_valid & full & ~pop_ok;

   // Next level: flush wins over any push or pop in the same cycle
   always_comb begin
      level_nxt = level;
      if (flush) begin
         level_nxt = '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
         endcase
      end
   end

   // Pointers, level and the threshold interrupt register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         thresh_irq <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         end
         level      <= level_nxt;
         thresh_irq <= (thresh != '0) && (level_nxt >= thresh);
      end
   end

   // Sticky overrun: a dropped byte sets it, and set beats clear
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)           overrun <= 1'b0;
      else if (drop)        overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
   end

   uart_fifo_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .ACLK  (ACLK),
      .we    (push_ok & ~flush),
      .waddr (wr_ptr[IDX_W-1:0]),
      .wdata (rx_byte),
      .raddr (rd_ptr[IDX_W-1:0]),
      .rdata (ram_rdata)
   );

   assign rd_data = empty ? '0 : ram_rdata;

`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TO_PRE = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] to_cnt;

   // Idle counter: restarts on any FIFO activity, counts only while
   // bytes are waiting, and flags once the limit is reached
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         to_cnt      <= '0;
         timeout_irq <= 1'b0;
      end else if (push_ok | pop_ok | flush) begin
         to_cnt      <= '0;
         timeout_irq <= 1'b0;
      end else if (level != '0) begin
         if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
         if (to_cnt >= TO_PRE) timeout_irq <= 1'b1;
      end
   end
`else
   assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (DEPTH = 16).
module tb_uart_rx_fifo;

   localparam int DEPTH   = 16;
   localparam int LEVEL_W = 5;
   localparam int TO_CYC  = 20832;

   logic               ACLK = 1'b0;
   logic               ARESET;
   logic               rx_byte_valid;
   logic [7:0]         rx_byte;
   logic               rd_pop;
   logic               flush;
   logic [LEVEL_W-1:0] thresh;
   logic               overrun_clr;
   logic [7:0]         rd_data;
   logic               empty;
   logic               full;
   logic [LEVEL_W-1:0] level;
   logic               overrun;
   logic               thresh_irq;
   logic               timeout_irq;

   int checks = 0;
   int errors = 0;

   uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .rx_byte_valid (rx_byte_valid),
      .rx_byte       (rx_byte),
      .rd_pop        (rd_pop),
      .flush         (flush),
      .thresh        (thresh),
      .overrun_clr   (overrun_clr),
      .rd_data       (rd_data),
      .empty         (empty),
      .full          (full),
      .level         (level),
      .overrun       (overrun),
      .thresh_irq    (thresh_irq),
      .timeout_irq   (timeout_irq)
   );

   always #5 ACLK = ~ACLK;

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      rx_byte_valid = 1'b1;
      rx_byte       = b;
      tick();
      rx_byte_valid = 1'b0;
   endtask

   task automatic pop();
      rd_pop = 1'b1;
      tick();
      rd_pop = 1'b0;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      rx_byte_valid = 1'b0; rx_byte = 8'h00; rd_pop = 1'b0; flush = 1'b0;
      thresh = '0; overrun_clr = 1'b0;
      repeat (3) tick();
      ARESET = 1'b0;
      tick();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
      checks++; if (thresh_irq !== 1'b0) begin errors++; $display("FAIL reset_thresh_irq got %b exp 0", thresh_irq); end
      checks++; if (timeout_irq !== 1'b0) begin errors++; $display("FAIL reset_timeout_irq got %b exp 0", timeout_irq); end
   endtask

   task automatic test_single();
      push(8'h83);
      checks++; if (rd_data !== 8'h83) begin errors++; $display("FAIL single_rd_data got %h exp 83", rd_data); end
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", empty); end
      pop();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b exp 1", empty); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL single_pop_rd_data got %h exp 00", rd_data); end
      // pop while empty is ignored
      pop();
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL underflow_level got %0d exp 0", level); end
   endtask

   task automatic test_fill_overrun();
      for (int i = 0; i < DEPTH; i++) push(8'(i));
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d exp 16", level); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fill_overrun_pre got %b exp 0", overrun); end
      push(8'hAA);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", overrun); end
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL overrun_level got %0d exp 16", level); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (rd_data !== 8'(i)) begin errors++; $display("FAIL drain_order[%0d] got %h exp %h", i, rd_data, 8'(i)); end
         pop();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", overrun); end
      overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got %b exp 0", overrun); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i));
      rx_byte_valid = 1'b1; rx_byte = 8'h55; rd_pop = 1'b1;
      tick();
      rx_byte_valid = 1'b0; rd_pop = 1'b0;
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_pushpop_level got %0d exp 16", level); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_pushpop_overrun got %b exp 0", overrun); end
      for (int i = 1; i < DEPTH; i++) begin
         checks++;
         if (rd_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_pushpop_order[%0d] got %h exp %h", i, rd_data, 8'h10 + 8'(i)); end
         pop();
      end
      checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL full_pushpop_last got %h exp 55", rd_data); end
      pop();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_pushpop_empty got %b exp 1", empty); end
      rx_byte_valid = 1'b1; rx_byte = 8'h55; rd_pop = 1'b1;
      tick();
      rx_byte_valid = 1'b0; rd_pop = 1'b0;
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL empty_pushpop_level got %0d exp 1", level); end
      checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL empty_pushpop_rd_data got %h exp 55", rd_data); end
      pop();
   endtask

   task automatic test_threshold();
      thresh = 5'd4;
      for (int i = 1; i <= 3; i++) begin
         push(8'hC0 + 8'(i));
         checks++; if (thresh_irq !== 1'b0) begin errors++; $display("FAIL thresh_below[%0d] got %b exp 0", i, thresh_irq); end
      end
      push(8'hC4);
      checks++; if (thresh_irq !== 1'b1) begin errors++; $display("FAIL thresh_reach got %b exp 1", thresh_irq); end
      pop();
      checks++; if (thresh_irq !== 1'b0) begin errors++; $display("FAIL thresh_drop got %b exp 0", thresh_irq); end
      for (int i = 0; i < 13; i++) push(8'(i));
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL thresh_fill_level got %0d exp 16", level); end
      thresh = 5'd16; tick();
      checks++; if (thresh_irq !== 1'b1) begin errors++; $display("FAIL thresh_16 got %b exp 1", thresh_irq); end
      thresh = 5'd0; tick();
      checks++; if (thresh_irq !== 1'b0) begin errors++; $display("FAIL thresh_zero got %b exp 0", thresh_irq); end
      flush = 1'b1; tick(); flush = 1'b0;
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL thresh_flush_level got %0d exp 0", level); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < DEPTH; i++) push(8'h20 + 8'(i));
      push(8'hEE);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL flush_pre_overrun got %b exp 1", overrun); end
      repeat (9) pop();
      checks++; if (level !== 5'd7) begin errors++; $display("FAIL flush_pre_level got %0d exp 7", level); end
      flush = 1'b1; rx_byte_valid = 1'b1; rx_byte = 8'h99;
      tick();
      flush = 1'b0; rx_byte_valid = 1'b0;
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL flush_rd_data got %h exp 00", rd_data); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL flush_overrun_kept got %b exp 1", overrun); end
      push(8'h41);
      checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL flush_then_push got %h exp 41", rd_data); end
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL flush_then_level got %0d exp 1", level); end
      // set beats clear in the same cycle
      for (int i = 0; i < DEPTH - 1; i++) push(8'(i));
      rx_byte_valid = 1'b1; rx_byte = 8'h77; overrun_clr = 1'b1;
      tick();
      rx_byte_valid = 1'b0; overrun_clr = 1'b0;
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_priority got %b exp 1", overrun); end
      overrun_clr = 1'b1; flush = 1'b1; tick(); overrun_clr = 1'b0; flush = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_final_clr got %b exp 0", overrun); end
   endtask

   task automatic test_timeout();
      logic exp_on;
`ifdef UART_RX_FIFO_TIMEOUT_EN
      exp_on = 1'b1;
`else
      exp_on = 1'b0;
`endif
      push(8'h5A);
      repeat (TO_CYC - 1) tick();
      checks++; if (timeout_irq !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", timeout_irq); end
      tick();
      checks++; if (timeout_irq !== exp_on) begin errors++; $display("FAIL timeout_set got %b exp %b", timeout_irq, exp_on); end
      repeat (5) tick();
      checks++; if (timeout_irq !== exp_on) begin errors++; $display("FAIL timeout_sticky got %b exp %b", timeout_irq, exp_on); end
      pop();
      checks++; if (timeout_irq !== 1'b0) begin errors++; $display("FAIL timeout_pop_clr got %b exp 0", timeout_irq); end
      repeat (TO_CYC + 5) tick();
      checks++; if (timeout_irq !== 1'b0) begin errors++; $display("FAIL timeout_empty got %b exp 0", timeout_irq); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overrun();
      test_back_to_back();
      test_threshold();
      test_flush();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
